// File: rtl/mem_responder_pkg.sv
// Shared address map and helpers for mem_responder.
// MMIO offsets and the NOP word are used by core and benches alike.
package mem_responder_pkg;

  localparam logic [31:0] TOHOST_OFF   = 32'h0000_0000;
  localparam logic [31:0] CYCLE_LO_OFF = 32'h0000_0004;
  localparam logic [31:0] CYCLE_HI_OFF = 32'h0000_0008;
  localparam logic [31:0] NOP_INSN     = 32'h0000_0013;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_TOHOST,
    REG_CYC_LO,
    REG_CYC_HI
  } mmio_reg_e;

  function automatic logic in_ram(
    input logic [31:0] addr,
    input int unsigned aw
  );
    return (addr >> (aw + 2)) == 32'd0;
  endfunction

  // Byte lane bits are ignored so any byte of a register word hits it.
  function automatic mmio_reg_e mmio_decode(
    input logic [31:0] addr,
    input logic [31:0] base
  );
    logic [31:0] w;
    w = {addr[31:2], 2'b00};
    if (w == base + TOHOST_OFF)
      return REG_TOHOST;
    if (w == base + CYCLE_LO_OFF)
      return REG_CYC_LO;
    if (w == base + CYCLE_HI_OFF)
      return REG_CYC_HI;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/mem_responder_mmio.sv
// MMIO decode, TOHOST register and optional 64-bit cycle counter.
// Define MMIO_CYCLE_CTR_EN to build the counter behind CYCLE_LO/HI.
module mmio_regs
  import mem_responder_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic        w_enable,
  input  logic [31:0] wdata,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        tohost_valid,
  output logic [31:0] tohost_data
);

  mmio_reg_e   sel;
  logic [31:0] cyc_lo;
  logic [31:0] cyc_hi;
  logic        th_write;

  assign sel      = mmio_decode(addr, MMIO_BASE);
  assign hit      = sel != REG_NONE;
  assign th_write = w_enable && (sel == REG_TOHOST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tohost_valid <= 1'b0;
      tohost_data  <= '0;
    end else begin
      tohost_valid <= th_write;
      if (th_write)
        tohost_data <= wdata;
    end
  end

`ifdef MMIO_CYCLE_CTR_EN
  logic [63:0] cycles;

  always_ff @(posedge clk) begin
    if (!reset_n)
      cycles <= '0;
    else
      cycles <= cycles + 64'd1;
  end

  assign cyc_lo = cycles[31:0];
  assign cyc_hi = cycles[63:32];
`else
  assign cyc_lo = '0;
  assign cyc_hi = '0;
`endif

  // TOHOST and unmapped reads fall to the zero default.
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel == REG_CYC_LO: rdata = cyc_lo;
      sel == REG_CYC_HI: rdata = cyc_hi;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Dual-port (fetch + data) RAM responder with MMIO window.
// Optional cycle counter: MMIO_CYCLE_CTR_EN (see mmio_regs).
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] rom_addr,
  output logic [31:0] rom_rdata,
  input  logic [31:0] mem_addr,
  input  logic        mem_r_enable,
  input  logic        mem_w_enable,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        tohost_valid,
  output logic [31:0] tohost_data,
  output logic        bus_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   ram [DEPTH_WORDS];
  logic [AW-1:0] rom_idx;
  logic [AW-1:0] mem_idx;
  logic          rom_in_ram;
  logic          mem_in_ram;
  logic          mmio_hit;
  logic [31:0]   mmio_rdata;
  logic          req;
  logic          unmapped;

  assign rom_idx    = rom_addr[AW+1:2];
  assign mem_idx    = mem_addr[AW+1:2];
  assign rom_in_ram = in_ram(rom_addr, AW);
  assign mem_in_ram = in_ram(mem_addr, AW);
  assign req        = mem_r_enable | mem_w_enable;
  assign unmapped   = !mem_in_ram && !mmio_hit;

  mmio_regs #(
    .MMIO_BASE(MMIO_BASE)
  ) u_mmio (
    .clk         (clk),
    .reset_n     (reset_n),
    .addr        (mem_addr),
    .w_enable    (mem_w_enable),
    .wdata       (mem_wdata),
    .hit         (mmio_hit),
    .rdata       (mmio_rdata),
    .tohost_valid(tohost_valid),
    .tohost_data (tohost_data)
  );

  // RAM survives reset; writes during reset are dropped.
  always_ff @(posedge clk) begin
    if (reset_n && mem_w_enable && mem_in_ram)
      ram[mem_idx] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      rom_rdata <= '0;
    else if (rom_in_ram)
      rom_rdata <= ram[rom_idx];
    else
      rom_rdata <= NOP_INSN;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      mem_rdata <= '0;
    else if (mem_r_enable)
      mem_rdata <= mem_in_ram ? ram[mem_idx]
                              : mmio_rdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      bus_err <= 1'b0;
    else if (req && unmapped)
      bus_err <= 1'b1;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder.
// Counter expectations follow MMIO_CYCLE_CTR_EN.
module tb_mem_responder;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk;
  logic        reset_n;
  logic [31:0] rom_addr;
  logic [31:0] rom_rdata;
  logic [31:0] mem_addr;
  logic        mem_r_enable;
  logic        mem_w_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        tohost_valid;
  logic [31:0] tohost_data;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  mem_responder #(
    .DEPTH_WORDS(4096),
    .MMIO_BASE  (BASE)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rom_addr    (rom_addr),
    .rom_rdata   (rom_rdata),
    .mem_addr    (mem_addr),
    .mem_r_enable(mem_r_enable),
    .mem_w_enable(mem_w_enable),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .tohost_valid(tohost_valid),
    .tohost_data (tohost_data),
    .bus_err     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_addr     = a;
    mem_wdata    = d;
    mem_w_enable = 1'b1;
    tick();
    mem_w_enable = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    mem_addr     = a;
    mem_r_enable = 1'b1;
    tick();
    mem_r_enable = 1'b0;
  endtask

  initial begin
    logic [31:0] cyc_exp;
    reset_n      = 1'b0;
    rom_addr     = '0;
    mem_addr     = '0;
    mem_r_enable = 1'b0;
    mem_w_enable = 1'b0;
    mem_wdata    = '0;
    tick();
    tick();
    check("rst_rom", rom_rdata, 32'h0);
    check("rst_mem", mem_rdata, 32'h0);
    check("rst_thv", {31'd0, tohost_valid}, 32'd0);
    check("rst_thd", tohost_data, 32'h0);
    check("rst_err", {31'd0, bus_err}, 32'd0);

    // counter: 10 edges after release, then request
    reset_n = 1'b1;
    repeat (10) tick();
    rd(BASE + 32'h4);
`ifdef MMIO_CYCLE_CTR_EN
    cyc_exp = 32'd10;
`else
    cyc_exp = 32'd0;
`endif
    check("cyc_lo", mem_rdata, cyc_exp);
    rd(BASE + 32'h8);
    check("cyc_hi", mem_rdata, 32'h0);
    check("cyc_noerr", {31'd0, bus_err}, 32'd0);

    // fetch port
    wr(32'h4, 32'h0050_0093);
    rom_addr = 32'h4;
    tick();
    check("rom_w1", rom_rdata, 32'h0050_0093);
    rom_addr = 32'h7;
    tick();
    check("rom_lsb", rom_rdata, 32'h0050_0093);
    rom_addr = 32'h2000_0000;
    tick();
    check("rom_nop", rom_rdata, 32'h0000_0013);

    // data write/read with ignored byte offset and hold
    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h12);
    check("rd_12", mem_rdata, 32'hDEAD_BEEF);
    mem_addr = 32'h4;
    tick();
    check("rd_hold", mem_rdata, 32'hDEAD_BEEF);

    // same-cycle read+write
    wr(32'h20, 32'd5);
    mem_addr     = 32'h20;
    mem_wdata    = 32'd9;
    mem_r_enable = 1'b1;
    mem_w_enable = 1'b1;
    tick();
    mem_r_enable = 1'b0;
    mem_w_enable = 1'b0;
    check("rbw_old", mem_rdata, 32'd5);
    rd(32'h20);
    check("rbw_new", mem_rdata, 32'd9);

    // fetch sees old data on same-cycle write
    wr(32'h24, 32'd7);
    rom_addr     = 32'h24;
    mem_addr     = 32'h24;
    mem_wdata    = 32'd8;
    mem_w_enable = 1'b1;
    tick();
    mem_w_enable = 1'b0;
    check("rom_old", rom_rdata, 32'd7);
    tick();
    check("rom_new", rom_rdata, 32'd8);

    // tohost
    wr(BASE, 32'd1);
    check("th_v1", {31'd0, tohost_valid}, 32'd1);
    check("th_d1", tohost_data, 32'd1);
    tick();
    check("th_v0", {31'd0, tohost_valid}, 32'd0);
    check("th_hold", tohost_data, 32'd1);
    mem_addr     = BASE;
    mem_wdata    = 32'd2;
    mem_w_enable = 1'b1;
    tick();
    check("th_b2v", {31'd0, tohost_valid}, 32'd1);
    check("th_b2d", tohost_data, 32'd2);
    mem_wdata = 32'd3;
    tick();
    mem_w_enable = 1'b0;
    check("th_b3v", {31'd0, tohost_valid}, 32'd1);
    check("th_b3d", tohost_data, 32'd3);
    tick();
    check("th_end", {31'd0, tohost_valid}, 32'd0);
    rd(BASE);
    check("th_rd0", mem_rdata, 32'h0);
    wr(BASE + 32'h4, 32'hFFFF_FFFF);
    check("cyc_wr_th", tohost_data, 32'd3);

    // RAM top word, then bus errors
    wr(32'h3FFC, 32'hA5A5_5A5A);
    rd(32'h3FFC);
    check("ram_top", mem_rdata, 32'hA5A5_5A5A);
    check("top_noerr", {31'd0, bus_err}, 32'd0);
    rd(32'h2000_0000);
    check("un_rd", mem_rdata, 32'h0);
    check("un_err", {31'd0, bus_err}, 32'd1);
    rd(32'h10);
    tick();
    check("err_stky", {31'd0, bus_err}, 32'd1);

    // reset clears flags, keeps RAM, drops requests
    reset_n      = 1'b0;
    mem_addr     = 32'h10;
    mem_wdata    = 32'h1234_5678;
    mem_w_enable = 1'b1;
    mem_r_enable = 1'b1;
    tick();
    mem_w_enable = 1'b0;
    mem_r_enable = 1'b0;
    check("r2_err", {31'd0, bus_err}, 32'd0);
    check("r2_mem", mem_rdata, 32'h0);
    check("r2_thd", tohost_data, 32'h0);
    reset_n = 1'b1;
    rd(32'h10);
    check("r2_keep", mem_rdata, 32'hDEAD_BEEF);
    rd(32'h4000);
    check("oob_err", {31'd0, bus_err}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096, giving the RAM size in 32-bit words (power of two).
REQ-002 SHALL have parameter MMIO_BASE, default 32'h1000_0000, giving the base of the register window.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port rom_addr  input  32  instruction fetch byte address.
REQ-006 SHALL have port rom_rdata  output  32  registered instruction word.
REQ-007 SHALL have port mem_addr  input  32  data byte address.
REQ-008 SHALL have port mem_r_enable  input  1  data read request.
REQ-009 SHALL have port mem_w_enable  input  1  data write request.
REQ-010 SHALL have port mem_wdata  input  32  data write word.
REQ-011 SHALL have port mem_rdata  output  32  registered data read word.
REQ-012 SHALL have port tohost_valid  output  1  one-cycle pulse when the TOHOST register is written.
REQ-013 SHALL have port tohost_data  output  32  last value written to TOHOST.
REQ-014 SHALL have port bus_err  output  1  sticky flag for accesses that fall outside both the RAM and the MMIO window.

Function
REQ-015 SHALL implement one shared RAM array, word-indexed by addr[log2(DEPTH_WORDS)+1:2], and SHALL ignore addr[1:0] on both ports.
REQ-016 SHALL decode the map as: RAM at 0 .. DEPTH_WORDS*4-1; TOHOST at MMIO_BASE+0x0; CYCLE_LO at MMIO_BASE+0x4; CYCLE_HI at MMIO_BASE+0x8; every other address is unmapped.
REQ-017 SHALL update rom_rdata every cycle with RAM[rom_addr] (1-cycle latency, no enable); an unmapped rom_addr SHALL return 32'h0000_0013 (NOP).
REQ-018 SHALL load mem_rdata one cycle after a cycle with mem_r_enable=1, and SHALL hold its value while mem_r_enable=0.
REQ-019 SHALL perform a full-word write at the edge where mem_w_enable=1: RAM for a RAM address, the TOHOST register for TOHOST; writes to CYCLE_LO/HI and to unmapped addresses SHALL be dropped.
REQ-020 SHALL give read-before-write behaviour when a read and a write hit the same address in the same cycle (either port returns the old data); the new data SHALL be visible from the next request onward.
REQ-021 SHALL, when mem_r_enable and mem_w_enable are both 1, perform both operations, the read returning the old data.
REQ-022 SHALL assert tohost_valid for exactly the cycle after a TOHOST write and update tohost_data at the same edge; back-to-back writes SHALL give consecutive pulses.
REQ-023 SHALL keep a 64-bit free-running cycle counter that increments by 1 every cycle out of reset and wraps from 2^64-1 to 0.
REQ-024 SHALL return counter[31:0] on a CYCLE_LO read and counter[63:32] on a CYCLE_HI read, sampled at the request edge.
REQ-025 SHALL return 0 for a read of TOHOST or of an unmapped address.
REQ-026 SHALL set bus_err on any enabled access to an unmapped address; bus_err SHALL clear only on reset.

Reset
REQ-027 SHALL, on a clk edge with reset_n=0, clear rom_rdata, mem_rdata, tohost_valid, tohost_data, bus_err and the counter.
REQ-028 SHALL NOT clear RAM contents on reset.
REQ-029 SHALL discard any write or read request that occurs during a reset cycle.
REQ-030 SHALL start the counter at 1 on the first edge after reset_n rises.

Configuration
REQ-031 SHALL implement the cycle counter and CYCLE_LO/HI when the macro MMIO_CYCLE_CTR_EN is defined.
REQ-032 SHALL, without MMIO_CYCLE_CTR_EN, remove the counter; CYCLE_LO/HI SHALL then read 0 and be treated as mapped, so bus_err is not set.

Structure
REQ-033 SHALL take the MMIO offsets (TOHOST/CYCLE_LO/CYCLE_HI) and the NOP constant from the shared def package, so the core and benches use the same address map.
REQ-034 SHALL place the MMIO decode, TOHOST register and counter in one sub-module, mmio_regs; the RAM array and the port mux SHALL stay in mem_responder.

Verification
REQ-035 SHALL cover: preload RAM[1]=32'h00500093, rom_addr=4 -> rom_rdata=32'h00500093 one cycle later.
REQ-036 SHALL cover: write 32'hDEADBEEF to 0x10, then read 0x12 -> mem_rdata=32'hDEADBEEF one cycle after the read request.
REQ-037 SHALL cover: same-cycle read+write to 0x20 (old value 5, new value 9) -> read returns 5, and the next read returns 9.
REQ-038 SHALL cover: write 1 to MMIO_BASE -> tohost_valid=1 for exactly one cycle, tohost_data=1.
REQ-039 SHALL cover: with MMIO_CYCLE_CTR_EN, a read of MMIO_BASE+4 issued 10 cycles after reset release -> mem_rdata=10; without the macro -> mem_rdata=0.
REQ-040 SHALL cover: read 0x2000_0000 -> mem_rdata=0 and bus_err=1, held until reset_n=0, then cleared.
